// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Module : mem_port_arbiter_pkg
// Brief  : Shared constants and FSM state encoding for the memory port arbiter.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_port_arbiter_pkg;

    localparam int INSTR_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SERVE_I = 2'd1,
        ST_SERVE_D = 2'd2
    } arb_state_e;

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// ============================================================================
// Module : mem_arb_pick
// Brief  : Fetch/data winner selection; optional starvation guard enabled by
//          the ARB_STARVE_GUARD_EN macro.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arb_pick #(
    parameter int STARVE_MAX = 3
) (
`ifdef ARB_STARVE_GUARD_EN
    input  logic clk,
    input  logic rst,
`endif
    input  logic arb_en,
    input  logic if_req,
    input  logic d_req,
    output logic pick_i,
    output logic pick_d
);

    if (STARVE_MAX < 1) begin : g_starve_max_chk
        $error("mem_arb_pick: STARVE_MAX must be at least 1");
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             fetch_first;

    always_comb begin
        fetch_first = (cnt_q == CNT_W'(STARVE_MAX));
        pick_d      = arb_en & d_req & ~(if_req & fetch_first);
        pick_i      = arb_en & if_req & ~pick_d;
        cnt_d       = cnt_q;
        // A data win over a waiting fetch can only occur below the limit, so
        // the increment saturates naturally at STARVE_MAX.
        if (pick_i) begin
            cnt_d = '0;
        end else if (pick_d && if_req) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    always_comb begin
        pick_d = arb_en & d_req;
        pick_i = arb_en & if_req & ~d_req;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Arbitrates fetch and data requesters onto one single-port memory.
//          Define ARB_STARVE_GUARD_EN to bound fetch starvation.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = INSTR_SIZE,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_valid,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [ADDR_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_valid,
    output logic [ADDR_W-1:0] rdata,
    output logic              m_req,
    output logic              m_we,
    output logic [ADDR_W-1:0] m_addr,
    output logic [ADDR_W-1:0] m_wdata,
    input  logic              m_ack,
    input  logic [ADDR_W-1:0] m_rdata
);

    arb_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] wdata_q, wdata_d;
    logic [ADDR_W-1:0] rdata_q, rdata_d;
    logic              we_q, we_d;
    logic              if_valid_q, if_valid_d;
    logic              d_valid_q, d_valid_d;
    logic              arb_en;
    logic              pick_i, pick_d;

    // Grants are combinational, so they are also masked while reset is held.
    assign arb_en = (state_q == ST_IDLE) & ~rst;

    mem_arb_pick #(
        .STARVE_MAX (STARVE_MAX)
    ) u_pick (
`ifdef ARB_STARVE_GUARD_EN
        .clk    (clk),
        .rst    (rst),
`endif
        .arb_en (arb_en),
        .if_req (if_req),
        .d_req  (d_req),
        .pick_i (pick_i),
        .pick_d (pick_d)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        we_d       = we_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pick_d) begin
                    state_d = ST_SERVE_D;
                    addr_d  = d_addr;
                    we_d    = d_we;
                    wdata_d = d_wdata;
                end else if (pick_i) begin
                    state_d = ST_SERVE_I;
                    addr_d  = if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                end
            end
            ST_SERVE_I, ST_SERVE_D: begin
                if (m_ack) begin
                    state_d    = ST_IDLE;
                    rdata_d    = we_q ? '0 : m_rdata;
                    if_valid_d = (state_q == ST_SERVE_I);
                    d_valid_d  = (state_q == ST_SERVE_D);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            we_q       <= 1'b0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            we_q       <= we_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
        end
    end

    assign if_gnt   = pick_i;
    assign d_gnt    = pick_d;
    assign if_valid = if_valid_q;
    assign d_valid  = d_valid_q;
    assign rdata    = rdata_q;
    assign m_req    = (state_q != ST_IDLE);
    assign m_we     = m_req & we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Self-checking bench for mem_port_arbiter with a transaction-level
//          reference model and directed scenarios.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int SMAX = 3;
`ifdef ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [AW-1:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic          if_gnt, if_valid, d_gnt, d_valid;
    logic [AW-1:0] rdata, m_addr, m_wdata;
    logic          m_req, m_we;
    logic          mem_ack = 1'b0, stray_ack = 1'b0;
    logic          m_ack;
    logic [AW-1:0] m_rdata = '0;

    assign m_ack = mem_ack | stray_ack;

    int n_chk  = 0;
    int n_fail = 0;

    mem_port_arbiter #(.ADDR_W(AW), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_valid(d_valid), .rdata(rdata),
        .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_ack(m_ack), .m_rdata(m_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] mem_word(input logic [AW-1:0] a);
        if (a == 32'h100) return 32'h0050_0093;
        return a ^ 32'h5A5A_0000;
    endfunction

    // Memory: acknowledges on the ack_delay-th cycle of a request.
    int ack_delay = 1;
    int wcnt      = 0;
    always @(posedge clk) begin
        #1;
        if (rst || !m_req || mem_ack) begin
            mem_ack = 1'b0;
            wcnt    = 0;
        end else begin
            wcnt++;
            if (wcnt >= ack_delay) begin
                mem_ack = 1'b1;
                m_rdata = mem_word(m_addr);
            end
        end
    end

    // Reference model: one outstanding transaction, owner, latched request.
    bit          busy = 0, owner_d = 0, lwe = 0, iv = 0, dv = 0;
    logic [AW-1:0] laddr = '0, lwdata = '0, mrd = '0;
    int          starve = 0;
    bit          n_busy, n_owner_d, n_lwe, n_iv, n_dv;
    logic [AW-1:0] n_laddr, n_lwdata, n_mrd;
    int          n_starve;

    always @(negedge clk) begin
        bit e_gi, e_gd;
        if (rst) begin
            busy = 0; owner_d = 0; lwe = 0; iv = 0; dv = 0;
            laddr = '0; lwdata = '0; mrd = '0; starve = 0;
        end
        e_gi = 0;
        e_gd = 0;
        if (!busy && !rst) begin
            if (d_req && if_req) begin
                if (GUARD && starve >= SMAX) e_gi = 1;
                else                         e_gd = 1;
            end else begin
                e_gd = d_req;
                e_gi = if_req;
            end
        end
        check("if_gnt",   AW'(if_gnt),   AW'(e_gi));
        check("d_gnt",    AW'(d_gnt),    AW'(e_gd));
        check("m_req",    AW'(m_req),    AW'(busy));
        check("m_we",     AW'(m_we),     AW'(busy && lwe));
        check("m_addr",   m_addr,        laddr);
        if (busy && lwe) check("m_wdata", m_wdata, lwdata);
        check("rdata",    rdata,         mrd);
        check("if_valid", AW'(if_valid), AW'(iv));
        check("d_valid",  AW'(d_valid),  AW'(dv));
        check("valid_excl", AW'(if_valid && d_valid), '0);

        n_busy = busy; n_owner_d = owner_d; n_lwe = lwe; n_laddr = laddr;
        n_lwdata = lwdata; n_mrd = mrd; n_starve = starve; n_iv = 0; n_dv = 0;
        if (busy && m_ack) begin
            n_busy = 0;
            n_dv   = owner_d;
            n_iv   = !owner_d;
            n_mrd  = lwe ? '0 : m_rdata;
        end
        if (e_gd) begin
            n_busy = 1; n_owner_d = 1; n_laddr = d_addr; n_lwe = d_we; n_lwdata = d_wdata;
            if (if_req && starve < SMAX) n_starve = starve + 1;
        end
        if (e_gi) begin
            n_busy = 1; n_owner_d = 0; n_laddr = if_addr; n_lwe = 0; n_lwdata = '0;
            n_starve = 0;
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            busy = 0; owner_d = 0; lwe = 0; iv = 0; dv = 0;
            laddr = '0; lwdata = '0; mrd = '0; starve = 0;
        end else begin
            busy = n_busy; owner_d = n_owner_d; lwe = n_lwe; iv = n_iv; dv = n_dv;
            laddr = n_laddr; lwdata = n_lwdata; mrd = n_mrd; starve = n_starve;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int we_cyc, ng, dv_cnt;
        bit seen;
        logic [7:0] fmask;

        #1 rst = 1'b1;
        step(); step();
        rst = 1'b0;
        @(negedge clk);
        check("reset_m_addr", m_addr, '0);
        check("reset_rdata",  rdata,  '0);

        // Fetch only, single-cycle memory
        step(); ack_delay = 1; if_addr = 32'h100; if_req = 1;
        @(negedge clk); check("A_if_gnt", AW'(if_gnt), 1);
        step(); if_req = 0;
        @(negedge clk); check("A_m_addr", m_addr, 32'h100);
        check("A_m_req", AW'(m_req), 1);
        step();
        @(negedge clk); check("A_if_valid", AW'(if_valid), 1);
        check("A_rdata", rdata, 32'h0050_0093);

        // Simultaneous requests: data first, fetch granted on d_valid cycle
        step(); d_addr = 32'h2000; d_we = 0; if_addr = 32'h104; d_req = 1; if_req = 1;
        @(negedge clk); check("B_d_gnt", AW'(d_gnt), 1);
        check("B_if_gnt_low", AW'(if_gnt), 0);
        step(); d_req = 0;
        @(negedge clk); check("B_m_addr", m_addr, 32'h2000);
        step();
        @(negedge clk); check("B_d_valid", AW'(d_valid), 1);
        check("B_if_gnt", AW'(if_gnt), 1);
        check("B_rdata", rdata, 32'h5A5A_2000);
        step(); if_req = 0;
        @(negedge clk); check("B_m_addr_i", m_addr, 32'h104);
        step();
        @(negedge clk); check("B_if_valid", AW'(if_valid), 1);
        check("B_rdata_i", rdata, 32'h5A5A_0104);

        // Store with three-cycle memory
        step(); ack_delay = 3; d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk); check("C_d_gnt", AW'(d_gnt), 1);
        step(); d_req = 0; d_we = 0;
        we_cyc = 0; seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (d_valid) begin
                seen = 1;
                check("C_rdata_zero", rdata, '0);
                break;
            end
            if (m_we && m_wdata == 32'hDEAD_BEEF && m_addr == 32'h40) we_cyc++;
        end
        check("C_d_valid_seen", AW'(seen), 1);
        check("C_we_cycles", AW'(we_cyc), 3);

        // Stray ack while idle must be ignored
        step(); stray_ack = 1;
        @(negedge clk); check("D_m_req_idle", AW'(m_req), 0);
        step(); stray_ack = 0;
        @(negedge clk); check("D_no_if_valid", AW'(if_valid), 0);
        check("D_no_d_valid", AW'(d_valid), 0);

        // Continuous contention: fetch wins every fourth grant only with the guard
        step(); ack_delay = 1; d_addr = 32'h300; if_addr = 32'h200; d_we = 0;
        d_req = 1; if_req = 1;
        ng = 0; fmask = '0;
        for (int i = 0; i < 60 && ng < 8; i++) begin
            @(negedge clk);
            if (if_gnt || d_gnt) begin
                fmask[ng] = if_gnt;
                ng++;
            end
        end
        check("E_grant_count", AW'(ng), 8);
        check("E_fetch_mask", AW'(fmask), GUARD ? 32'h88 : 32'h00);
        step(); d_req = 0; if_req = 0;
        repeat (4) step();

        // Reset during an outstanding load
        step(); ack_delay = 5; d_req = 1; d_addr = 32'h80; d_we = 0;
        @(negedge clk); check("F_d_gnt", AW'(d_gnt), 1);
        step(); d_req = 0;
        @(negedge clk); check("F_m_req_before", AW'(m_req), 1);
        #2 rst = 1'b1;
        #1;
        check("F_m_req", AW'(m_req), 0);
        check("F_outs", AW'({if_gnt, d_gnt, if_valid, d_valid, m_we}), 0);
        check("F_m_addr", m_addr, '0);
        check("F_m_wdata", m_wdata, '0);
        check("F_rdata", rdata, '0);
        step(); step(); rst = 1'b0;
        dv_cnt = 0;
        repeat (8) begin
            @(negedge clk);
            if (d_valid) dv_cnt++;
        end
        check("F_no_d_valid", AW'(dv_cnt), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32 (INSTR_SIZE), meaning address and data width.
REQ-002 SHALL have parameter STARVE_MAX, default 3, meaning consecutive data wins allowed over a pending fetch.
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port if_req  input  1  fetch stage requests an instruction read.
REQ-006 SHALL have port if_addr  input  ADDR_W  fetch address (PC).
REQ-007 SHALL have port if_gnt  output  1  fetch request accepted this cycle.
REQ-008 SHALL have port if_valid  output  1  fetch read data valid on rdata.
REQ-009 SHALL have port d_req  input  1  data stage requests a load or store.
REQ-010 SHALL have port d_we  input  1  1 = store, 0 = load.
REQ-011 SHALL have port d_addr  input  ADDR_W  data address.
REQ-012 SHALL have port d_wdata  input  ADDR_W  store data.
REQ-013 SHALL have port d_gnt  output  1  data request accepted this cycle.
REQ-014 SHALL have port d_valid  output  1  data access complete; load data on rdata.
REQ-015 SHALL have port rdata  output  ADDR_W  read data shared by both requesters.
REQ-016 SHALL have ports m_req (output, 1), m_we (output, 1), m_addr (output, ADDR_W) and m_wdata (output, ADDR_W): request, write enable, address and write data to the single-port memory.
REQ-017 SHALL have ports m_ack (input, 1), memory access done this cycle, and m_rdata (input, ADDR_W), memory read data, valid with m_ack.

Function
REQ-018 SHALL implement the states IDLE, SERVE_I and SERVE_D.
REQ-019 In IDLE with any request pending, SHALL assert exactly one grant combinationally, latch that requester's addr/we/wdata, and move to SERVE_I or SERVE_D at the next edge.
REQ-020 When if_req and d_req are both high, the data request SHALL win, except as stated in REQ-029.
REQ-021 Grants SHALL be issued only in IDLE; a requester holds req until gnt and may drop it on the gnt cycle.
REQ-022 In SERVE_x, m_req SHALL be 1 and m_addr, m_we and m_wdata SHALL be stable from the latched values until m_ack.
REQ-023 On m_ack in SERVE_x, SHALL register m_rdata (0 for stores) into rdata, pulse if_valid or d_valid for exactly one cycle at the next edge, and return to IDLE.
REQ-024 In IDLE, m_req and m_we SHALL be 0; m_addr and rdata SHALL hold their last values.
REQ-025 Minimum transaction timing: gnt at cycle N, m_req at N+1, valid at N+2 if m_ack arrives at N+1; the next grant MAY coincide with the valid cycle.
REQ-026 m_ack received in IDLE SHALL be ignored.
REQ-027 if_valid and d_valid SHALL never both be high in the same cycle.

Reset
REQ-028 rst SHALL immediately force IDLE, drop m_req (an in-flight access is abandoned and never completed), and zero if_gnt, d_gnt, if_valid, d_valid, m_we, m_addr, m_wdata, rdata and the starvation counter.

Configuration
REQ-029 With ARB_STARVE_GUARD_EN defined, a counter SHALL increment on each data grant made while if_req is high, clear on each fetch grant, and saturate at STARVE_MAX; at STARVE_MAX, fetch SHALL win the next tie.
REQ-030 Without ARB_STARVE_GUARD_EN, SHALL use strict data priority with no counter logic.

Structure
REQ-031 The state encoding and the default ADDR_W, tied to INSTR_SIZE, SHALL live in the shared constants file.
REQ-032 Winner selection and the starvation counter SHALL be the sub-module mem_arb_pick; the FSM and datapath latches SHALL stay in mem_port_arbiter.

Verification
REQ-033 Fetch only, if_addr=0x100 with m_ack one cycle after m_req and m_rdata=0x00500093: if_gnt at N, if_valid at N+2, rdata=0x00500093.
REQ-034 Simultaneous requests, d_addr=0x2000 load and if_addr=0x104: d_gnt first with m_addr=0x2000, then if_gnt on the d_valid cycle.
REQ-035 Store d_we=1, d_addr=0x40, d_wdata=0xDEADBEEF with m_ack after 3 cycles: m_we=1 and m_wdata stable for 3 cycles, then d_valid with rdata=0.
REQ-036 With guard enabled: if_req and d_req held high continuously; after 3 data grants the 4th grant goes to fetch and the counter returns to 0; with guard disabled, fetch is never granted.
REQ-037 rst asserted in SERVE_D before m_ack: m_req drops in the same cycle, all outputs are 0, and no d_valid follows after reset is released.
